cgra_config_loader: RTL

//  Sequences CGRA configuration into top's config_addr_in/config_data_in ports: one (addr,data) word per cycle.

---
 rtl/cgra_config_loader_if.sv | 28 ++
 rtl/cgra_config_loader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cgra_config_loader_if.sv
// Valid/ready stream of (addr, data, last) configuration words
// from a host, JTAG bridge or boot ROM into the config loader.
interface cgra_config_loader_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              last;

   modport master (
      output valid,
      output addr,
      output data,
      output last,
      input  ready
   );

   modport slave (
      input  valid,
      input  addr,
      input  data,
      input  last,
      output ready
   );
endinterface

// File: rtl/cgra_config_loader.sv
// Buffers a configuration word stream and issues one (addr,data) per cycle
// to the CGRA fabric, then settles on address 0 and enables the application.
module cgra_config_loader #(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                 clk_in,
   input  logic                 reset_in,
   input  logic                 start_in,
   cgra_config_loader_if.slave  cfg,
   input  logic                 config_stall_in,
   output logic [ADDR_W-1:0]    config_addr_out,
   output logic [DATA_W-1:0]    config_data_out,
   output logic                 busy_out,
   output logic                 config_done_out,
   output logic                 run_en_out,
   output logic [15:0]          word_count_out,
   output logic                 err_out
);
   localparam int IDX_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int WRD_W = ADDR_W + DATA_W;
   localparam int SC_W  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_DRAIN  = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;

   logic [2:0]        r_state;
   logic [PTR_W-1:0]  r_wr;
   logic [PTR_W-1:0]  r_rd;
   logic [WRD_W-1:0]  r_mem [FIFO_DEPTH];
   logic [SC_W-1:0]   r_settle;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [15:0]       r_cnt;
   logic              r_err;

   logic              w_load;
   logic              w_drain;
   logic              w_settle;
   logic              w_busy;
   logic              w_idle_run;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_start_ok;
   logic              w_err_set;
   logic [WRD_W-1:0]  w_head;

   assign w_load     = (r_state == S_LOAD);
   assign w_drain    = (r_state == S_DRAIN);
   assign w_settle   = (r_state == S_SETTLE);
   assign w_busy     = w_load | w_drain | w_settle;
   assign w_idle_run = (r_state == S_IDLE) | (r_state == S_RUN);

   // Extra pointer MSB distinguishes full from empty on equal indices.
   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[IDX_W] != r_rd[IDX_W]) &&
                    (r_wr[IDX_W-1:0] == r_rd[IDX_W-1:0]);
   assign w_head  = r_mem[r_rd[IDX_W-1:0]];

   assign w_pop      = (w_load | w_drain) & ~config_stall_in & ~w_empty;
   // A pop frees a slot this cycle, so a full FIFO can still accept.
   assign cfg.ready  = w_load & (~w_full | w_pop);
   assign w_push     = cfg.valid & cfg.ready;
   assign w_start_ok = start_in & w_idle_run;
   assign w_err_set  = (start_in & w_busy) |
                       (cfg.valid & (w_drain | w_settle));

   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_mem[r_wr[IDX_W-1:0]] <= {cfg.addr, cfg.data};
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_state  <= S_IDLE;
         r_wr     <= '0;
         r_rd     <= '0;
         r_settle <= '0;
         r_addr   <= '0;
         r_data   <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;

         if (w_start_ok) begin
            r_err <= 1'b0;
            r_cnt <= '0;
         end else begin
            if (w_err_set) r_err <= 1'b1;
            if (w_pop && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
         end

         case (r_state)
            S_LOAD: begin
               if (w_pop) begin
                  {r_addr, r_data} <= w_head;
               end else if (!config_stall_in) begin
                  r_addr <= '0;
                  r_data <= '0;
               end
               if (w_push && cfg.last) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_pop) begin
                  {r_addr, r_data} <= w_head;
               end else if (!config_stall_in) begin
                  r_addr   <= '0;
                  r_data   <= '0;
                  r_settle <= SC_W'(SETTLE_CYCLES);
                  r_state  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               r_addr <= '0;
               r_data <= '0;
               if (r_settle == '0) r_state  <= S_RUN;
               else                r_settle <= r_settle - 1'b1;
            end
            S_IDLE, S_RUN: begin
               r_addr <= '0;
               r_data <= '0;
               if (start_in) r_state <= S_LOAD;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign config_addr_out = r_addr;
   assign config_data_out = r_data;
   assign busy_out        = w_busy;
   assign config_done_out = (r_state == S_RUN);
   assign run_en_out      = (r_state == S_RUN);
   assign word_count_out  = r_cnt;
   assign err_out         = r_err;
endmodule
